clk_div_multi: RTL and testbench
================================

// Module: clk_div_multi
// PURPOSE
//   Parametrised multi-channel programmable clock divider, successor to the fixed
//   single-output divider. Each of NCH channels divides the board clock cly by a
//   runtime-programmable half-period count, in toggle mode (50% duty) or pulse mode
//   (1-cycle strobe). Also emits a per-channel tick strobe. Feeds display scan,
//   debounce and slow-visible-clock logic in lab designs.
// PARAMETERS
//   NCH       4            number of divider channels (1..16)
//   CW        27           counter / half-period width in bits
//   CHW       2            width of wr_ch; must satisfy 2**CHW >= NCH
//   DEF_HALF  100000000    reset half-period count for every channel; nonzero, < 2**CW
// PORTS
//   cly      in   1      system clock; all logic on posedge
//   rst      in   1      asynchronous active-high reset
//   en       in   NCH    per-channel run enable
//   wr_en    in   1      1-cycle config write strobe
//   wr_ch    in   CHW    channel index for the write
//   wr_val   in   CW     new half-period count H
//   wr_mode  in   1      new mode: 0 = toggle, 1 = pulse
//   sync     in   1      restart all channels phase-aligned
//   clk_out  out  NCH    divided outputs (registered)
//   tick     out  NCH    1-cycle strobe at each terminal count (registered)
//   wr_err   out  1      1-cycle flag: previous write rejected
// BEHAVIOUR
//   State per channel: half[CW], mode, cnt[CW]. All outputs are registered.
//   Reset (async, any time, including mid-count):
//     half=DEF_HALF, mode=0, cnt=DEF_HALF, clk_out=0, tick=0, wr_err=0.
//   Counting (channel i, en[i]=1):
//     - cnt!=0: cnt<=cnt-1; tick[i]<=0; toggle mode: clk_out holds; pulse mode: clk_out<=0.
//     - cnt==0 (terminal): cnt<=half; tick[i]<=1.
//       Toggle mode: clk_out[i] <= ~clk_out[i]. Pulse mode: clk_out[i] <= 1.
//     - Terminal count occurs every H+1 enabled edges.
//       Toggle period = 2*(H+1) cycles. Pulse period = H+1 cycles, high for 1 cycle.
//   en[i]=0: cnt and clk_out[i] hold; tick[i]<=0. Counting resumes with no lost state.
//   Write (wr_en=1):
//     - Rejected if wr_val==0 or wr_ch>=NCH. No state change; wr_err<=1 next edge.
//     - Accepted: half<=wr_val, mode<=wr_mode, cnt<=wr_val, clk_out<=0, tick<=0,
//       wr_err<=0. The write restarts the channel regardless of en.
//     - An accepted write wins over a terminal count on the same channel in the same
//       cycle: no tick, no toggle.
//   sync=1: for every channel, cnt<=half, clk_out<=0, tick<=0 (regardless of en).
//     sync together with an accepted write: the written channel loads the new
//     wr_val/mode; all other channels sync.
//   wr_err is 0 in every cycle not following a rejected write.
//   Minimum legal H=1: toggle every 2 cycles (clk_out = cly/4).
//   cnt never wraps below 0; the reload path is the only way out of 0.
// TESTING  (bench overrides DEF_HALF=3, NCH=4, CW=8)
//   1. Release rst with en=4'hF -> clk_out[0] rises on edge 4 and falls on edge 8;
//      tick[0]=1 on edges 4 and 8 only.
//   2. Write ch1 H=1 mode=1 -> clk_out[1] is a 1-cycle pulse every 2 cycles,
//      matching tick[1]; other channels undisturbed.
//   3. Write wr_val=0, then wr_ch=5 on a wider CHW build -> wr_err pulses 1 cycle each
//      time; half/mode/cnt unchanged.
//   4. Drop en[2] mid-count for 10 cycles -> clk_out[2] and cnt frozen, tick[2]=0;
//      on re-enable, the next toggle arrives after exactly the remaining count.
//   5. Write ch0 on its terminal-count cycle, with sync in the same cycle -> ch0 loads
//      the new H with no tick; ch1-3 restart; all clk_out=0.
//   6. Assert rst mid-high-phase -> clk_out=0 and tick=0 immediately (async);
//      the reset sequence then repeats scenario 1.

Source files
------------

// File: rtl/clk_div_multi_if.sv
// Control/status bundle for the multi-channel clock divider.
// The master side drives run enables, configuration writes and the sync
// restart. The slave side returns the divided clocks, tick strobes and the
// write-reject flag.
interface clk_div_multi_if #(
    parameter int NCH = 4,
    parameter int CW  = 27,
    parameter int CHW = 2
);
    logic [NCH-1:0] en;
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_val;
    logic           wr_mode;
    logic           sync;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic           wr_err;

    modport master (
        output en, wr_en, wr_ch, wr_val, wr_mode, sync,
        input  clk_out, tick, wr_err
    );

    modport slave (
        input  en, wr_en, wr_ch, wr_val, wr_mode, sync,
        output clk_out, tick, wr_err
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel counts a programmable half-period down to zero. On the zero
// (terminal) edge it reloads and produces a tick. In toggle mode the output
// flips at every terminal count, giving a 50% duty clock. In pulse mode the
// output is high only on the terminal edge.
// A configuration write restarts its channel. sync restarts every channel
// that is not being written in the same cycle.
module clk_div_multi #(
    parameter int NCH      = 4,
    parameter int CW       = 27,
    parameter int CHW      = 2,
    parameter int DEF_HALF = 100000000
) (
    input  logic          cly,
    input  logic          rst,
    clk_div_multi_if.slave bus
);

    localparam logic [CW-1:0] DEF_HALF_C = CW'(DEF_HALF);
    localparam logic [CW-1:0] ZERO_C     = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C      = {{(CW-1){1'b0}}, 1'b1};

    // A write is only legal for an existing channel and a nonzero half-period.
    // A zero half-period would leave the counter permanently terminal.
    function automatic logic wr_legal(input logic [CHW-1:0] ch,
                                      input logic [CW-1:0]  val);
        logic ch_ok;
        logic val_ok;
        ch_ok    = (32'(ch) < 32'(NCH));
        val_ok   = (val != ZERO_C);
        wr_legal = ch_ok & val_ok;
    endfunction

    // Per-channel state.
    logic [CW-1:0]  half_r [NCH];
    logic           mode_r [NCH];
    logic [CW-1:0]  cnt_r  [NCH];
    logic [NCH-1:0] clk_out_r;
    logic [NCH-1:0] tick_r;
    logic           wr_err_r;

    // Next-state values.
    logic [CW-1:0]  half_s [NCH];
    logic           mode_s [NCH];
    logic [CW-1:0]  cnt_s  [NCH];
    logic [NCH-1:0] clk_out_s;
    logic [NCH-1:0] tick_s;
    logic           wr_err_s;
    logic           wr_acc_s;

    // Decode the write and compute every channel's next state.
    // Priority is: accepted write, then sync, then counting, then hold.
    always_comb begin
        wr_acc_s  = bus.wr_en & wr_legal(bus.wr_ch, bus.wr_val);
        wr_err_s  = bus.wr_en & ~wr_acc_s;
        clk_out_s = clk_out_r;
        tick_s    = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            half_s[i] = half_r[i];
            mode_s[i] = mode_r[i];
            cnt_s[i]  = cnt_r[i];
            if (wr_acc_s && (bus.wr_ch == CHW'(i))) begin
                // A write beats a coincident terminal count. There is no tick
                // and no toggle, and the channel restarts from the new value.
                half_s[i]    = bus.wr_val;
                mode_s[i]    = bus.wr_mode;
                cnt_s[i]     = bus.wr_val;
                clk_out_s[i] = 1'b0;
            end else if (bus.sync) begin
                cnt_s[i]     = half_r[i];
                clk_out_s[i] = 1'b0;
            end else if (bus.en[i]) begin
                if (cnt_r[i] == ZERO_C) begin
                    // The reload is the only exit from zero, so the counter
                    // never wraps.
                    cnt_s[i]  = half_r[i];
                    tick_s[i] = 1'b1;
                    if (mode_r[i]) begin
                        clk_out_s[i] = 1'b1;
                    end else begin
                        clk_out_s[i] = ~clk_out_r[i];
                    end
                end else begin
                    cnt_s[i] = cnt_r[i] - ONE_C;
                    if (mode_r[i]) begin
                        clk_out_s[i] = 1'b0;
                    end else begin
                        clk_out_s[i] = clk_out_r[i];
                    end
                end
            end else begin
                // A paused channel keeps its count and output level, so
                // counting resumes exactly where it stopped.
                cnt_s[i]     = cnt_r[i];
                clk_out_s[i] = clk_out_r[i];
            end
        end
    end

    // Register all channel state and outputs. Reset is asynchronous.
    always_ff @(posedge cly or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                half_r[i] <= DEF_HALF_C;
                mode_r[i] <= 1'b0;
                cnt_r[i]  <= DEF_HALF_C;
            end
            clk_out_r <= {NCH{1'b0}};
            tick_r    <= {NCH{1'b0}};
            wr_err_r  <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                half_r[i] <= half_s[i];
                mode_r[i] <= mode_s[i];
                cnt_r[i]  <= cnt_s[i];
            end
            clk_out_r <= clk_out_s;
            tick_r    <= tick_s;
            wr_err_r  <= wr_err_s;
        end
    end

    assign bus.clk_out = clk_out_r;
    assign bus.tick    = tick_r;
    assign bus.wr_err  = wr_err_r;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi.
// Directed scenarios are followed by a randomized phase. Every cycle is
// compared against a behavioural model that tracks, for each channel, the
// number of enabled edges remaining until the next terminal count.
module tb_clk_div_multi;
    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int CHW = 3;
    localparam int DEF = 3;

    logic cly = 1'b0;
    logic rst;

    clk_div_multi_if #(.NCH(NCH), .CW(CW), .CHW(CHW)) bus ();

    clk_div_multi #(.NCH(NCH), .CW(CW), .CHW(CHW), .DEF_HALF(DEF)) dut (
        .cly (cly),
        .rst (rst),
        .bus (bus)
    );

    always #5 cly = ~cly;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state.
    int             rem [NCH];   // enabled edges until the next terminal count
    int             hv  [NCH];
    bit             md  [NCH];
    logic [NCH-1:0] m_clk;
    logic [NCH-1:0] m_tick;
    logic           m_err;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            hv[i]  = DEF;
            md[i]  = 1'b0;
            rem[i] = DEF + 1;
        end
        m_clk  = '0;
        m_tick = '0;
        m_err  = 1'b0;
    endtask

    // Terminal counts arrive every H+1 enabled edges. A restart re-arms the
    // full interval.
    task automatic model_edge();
        bit acc;
        acc   = bus.wr_en && (bus.wr_val != 0) && (32'(bus.wr_ch) < NCH);
        m_err = bus.wr_en && !acc;
        for (int i = 0; i < NCH; i++) begin
            m_tick[i] = 1'b0;
            if (acc && (32'(bus.wr_ch) == i)) begin
                hv[i]    = int'(bus.wr_val);
                md[i]    = bus.wr_mode;
                rem[i]   = hv[i] + 1;
                m_clk[i] = 1'b0;
            end else if (bus.sync) begin
                rem[i]   = hv[i] + 1;
                m_clk[i] = 1'b0;
            end else if (bus.en[i]) begin
                rem[i] = rem[i] - 1;
                if (rem[i] == 0) begin
                    m_tick[i] = 1'b1;
                    m_clk[i]  = md[i] ? 1'b1 : ~m_clk[i];
                    rem[i]    = hv[i] + 1;
                end else if (md[i]) begin
                    m_clk[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge cly);
        #1;
        check_val("clk_out", 32'(bus.clk_out), 32'(m_clk));
        check_val("tick",    32'(bus.tick),    32'(m_tick));
        check_val("wr_err",  32'(bus.wr_err),  32'(m_err));
    endtask

    task automatic set_idle();
        bus.wr_en   = 1'b0;
        bus.wr_ch   = '0;
        bus.wr_val  = '0;
        bus.wr_mode = 1'b0;
        bus.sync    = 1'b0;
    endtask

    // Release reset with all channels enabled. Channel 0 rises on edge 4 and
    // falls on edge 8, ticking on exactly those two edges.
    task automatic reset_sequence();
        @(posedge cly);
        #1;
        check_val("rst_clk_out", 32'(bus.clk_out), 32'd0);
        check_val("rst_tick",    32'(bus.tick),    32'd0);
        check_val("rst_wr_err",  32'(bus.wr_err),  32'd0);
        rst = 1'b0;
        model_reset();
        for (int e = 1; e <= 8; e++) begin
            step();
            check_val("s1_clk0",  32'(bus.clk_out[0]), 32'(e >= 4 && e < 8));
            check_val("s1_tick0", 32'(bus.tick[0]),    32'(e == 4 || e == 8));
        end
    endtask

    initial begin
        int   r;
        int   n;
        logic held;

        rst    = 1'b1;
        bus.en = '1;
        set_idle();
        #2;
        reset_sequence();

        // Channel 1 in pulse mode with H=1.
        bus.wr_en = 1'b1; bus.wr_ch = 3'd1; bus.wr_val = 8'd1; bus.wr_mode = 1'b1;
        step();
        set_idle();
        for (int k = 1; k <= 8; k++) begin
            step();
            check_val("s2_pulse", 32'(bus.clk_out[1]), 32'(k % 2 == 0));
            check_val("s2_tick",  32'(bus.tick[1]),    32'(k % 2 == 0));
        end

        // Rejected writes: zero value, then out-of-range channels.
        bus.wr_en = 1'b1; bus.wr_ch = 3'd2; bus.wr_val = 8'd0; bus.wr_mode = 1'b1;
        step();
        check_val("s3_err_zero", 32'(bus.wr_err), 32'd1);
        set_idle();
        step();
        check_val("s3_err_clr0", 32'(bus.wr_err), 32'd0);
        bus.wr_en = 1'b1; bus.wr_ch = 3'd5; bus.wr_val = 8'd4; bus.wr_mode = 1'b1;
        step();
        check_val("s3_err_ch5", 32'(bus.wr_err), 32'd1);
        bus.wr_ch = 3'd4;
        step();
        check_val("s3_err_ch4", 32'(bus.wr_err), 32'd1);
        set_idle();
        step();
        check_val("s3_err_clr1", 32'(bus.wr_err), 32'd0);

        // Pause channel 2 for 10 cycles, then check the remaining interval.
        step();
        bus.en[2] = 1'b0;
        held = bus.clk_out[2];
        r    = rem[2];
        for (int k = 0; k < 10; k++) begin
            step();
            check_val("s4_hold", 32'(bus.clk_out[2]), 32'(held));
            check_val("s4_tick", 32'(bus.tick[2]),    32'd0);
        end
        bus.en[2] = 1'b1;
        for (int k = 1; k <= r; k++) begin
            step();
            check_val("s4_resume", 32'(bus.tick[2]), 32'(k == r));
        end

        // Write channel 0 on its terminal edge, with sync in the same cycle.
        n = 0;
        while (rem[0] != 1 && n < 50) begin
            step();
            n++;
        end
        check_val("s5_reach_terminal", 32'(rem[0]), 32'd1);
        bus.wr_en = 1'b1; bus.wr_ch = 3'd0; bus.wr_val = 8'd5; bus.wr_mode = 1'b0;
        bus.sync  = 1'b1;
        step();
        check_val("s5_no_tick", 32'(bus.tick),    32'd0);
        check_val("s5_all_low", 32'(bus.clk_out), 32'd0);
        set_idle();
        for (int k = 1; k <= 6; k++) begin
            step();
            check_val("s5_new_h", 32'(bus.tick[0]), 32'(k == 6));
        end

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            bus.en      = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
            bus.wr_en   = ($urandom_range(0, 7) == 0);
            bus.wr_ch   = CHW'($urandom_range(0, 7));
            bus.wr_val  = CW'($urandom_range(0, 6));
            bus.wr_mode = 1'($urandom_range(0, 1));
            bus.sync    = ($urandom_range(0, 31) == 0);
            step();
        end

        // Asynchronous reset in the middle of a high phase of channel 0.
        bus.en = '1;
        set_idle();
        bus.wr_en = 1'b1; bus.wr_ch = 3'd0; bus.wr_val = 8'd2; bus.wr_mode = 1'b0;
        step();
        set_idle();
        n = 0;
        while (m_clk[0] != 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_val("s6_high_phase", 32'(bus.clk_out[0]), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_val("s6_async_clk", 32'(bus.clk_out), 32'd0);
        check_val("s6_async_tick", 32'(bus.tick),   32'd0);
        reset_sequence();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
